mac_operand_sequencer: RTL

MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

---
 rtl/mac_operand_sequencer_pkg.sv | 19 +
 rtl/mac_pair_buffer.sv | 27 ++
 rtl/mac_operand_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_operand_sequencer_pkg.sv
// Shared types and widths for the MAC operand sequencer and its pair buffer.
package mac_operand_sequencer_pkg;

    localparam int OP_W   = 8;
    localparam int ACC_W  = 16;
    localparam int PAIR_W = 2 * OP_W;

    localparam logic [ACC_W-1:0] SAT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/mac_pair_buffer.sv
// DEPTH x 16-bit operand-pair register file: one write port, one asynchronous read port.
module mac_pair_buffer
    import mac_operand_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [PAIR_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [PAIR_W-1:0] rd_data
);

    logic [PAIR_W-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset; every entry read is written first in LOAD.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mac_operand_sequencer.sv
// Buffers a vector of operand pairs, then streams them into an external MAC and captures the result.
// Optional feature: define MAC_SEQ_SAT_FLAG_EN to add the sat_flag output.
module mac_operand_sequencer
    import mac_operand_sequencer_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clock,
    input  logic             reset_p,
    input  logic             start,
    input  logic [4:0]       vec_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    output logic [OP_W-1:0]  mac_a,
    output logic [OP_W-1:0]  mac_b,
    output logic             mac_clr,
    input  logic [ACC_W-1:0] mac_s,
    output logic [ACC_W-1:0] result,
    output logic             done,
`ifdef MAC_SEQ_SAT_FLAG_EN
    output logic             sat_flag,
`endif
    output logic             busy
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DW    = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic [OP_W-1:0]   mac_a_q, mac_a_d;
    logic [OP_W-1:0]   mac_b_q, mac_b_d;
    logic              mac_clr_q, mac_clr_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;
`ifdef MAC_SEQ_SAT_FLAG_EN
    logic              sat_flag_q, sat_flag_d;
`endif

    logic              xfer_s;
    logic              buf_we_s;
    logic [AW-1:0]     buf_wr_addr_s;
    logic [AW-1:0]     buf_rd_addr_s;
    logic [PAIR_W-1:0] buf_wr_data_s;
    logic [PAIR_W-1:0] buf_rd_data_s;

    assign xfer_s        = in_valid && in_ready_q;
    assign buf_wr_addr_s = AW'(wr_cnt_q);
    assign buf_wr_data_s = {in_a, in_b};

    mac_pair_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buffer (
        .clock   (clock),
        .wr_en   (buf_we_s),
        .wr_addr (buf_wr_addr_s),
        .wr_data (buf_wr_data_s),
        .rd_addr (buf_rd_addr_s),
        .rd_data (buf_rd_data_s)
    );

    // Next-state, counters and result capture.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        drain_d  = drain_q;
        result_d = result_q;
`ifdef MAC_SEQ_SAT_FLAG_EN
        sat_flag_d = sat_flag_q;
`endif
        buf_we_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (vec_len == 5'd0) begin
                        len_d    = {CNT_W{1'b0}};
                        result_d = {ACC_W{1'b0}};
`ifdef MAC_SEQ_SAT_FLAG_EN
                        sat_flag_d = 1'b0;
`endif
                        state_d  = ST_DONE;
                    end else begin
                        len_d    = (32'(vec_len) > DEPTH) ? CNT_W'(DEPTH) : CNT_W'(vec_len);
                        wr_cnt_d = {CNT_W{1'b0}};
                        state_d  = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    buf_we_s = 1'b1;
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    if (wr_cnt_q == len_q - CNT_W'(1)) begin
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_CLEAR: begin
                rd_cnt_d = {CNT_W{1'b0}};
                state_d  = ST_STREAM;
            end
            ST_STREAM: begin
                if (rd_cnt_q == len_q - CNT_W'(1)) begin
                    drain_d = {DW{1'b0}};
                    if (DRAIN_CYCLES == 0) begin
                        result_d = mac_s;
`ifdef MAC_SEQ_SAT_FLAG_EN
                        sat_flag_d = (mac_s == SAT_MAX);
`endif
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                    result_d = mac_s;
`ifdef MAC_SEQ_SAT_FLAG_EN
                    sat_flag_d = (mac_s == SAT_MAX);
`endif
                    state_d  = ST_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        buf_rd_addr_s = AW'(rd_cnt_d);
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        mac_clr_d  = (state_d == ST_CLEAR);
        done_d     = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
        in_ready_d = (state_d == ST_LOAD);
        if (state_d == ST_STREAM) begin
            mac_a_d = buf_rd_data_s[PAIR_W-1:OP_W];
            mac_b_d = buf_rd_data_s[OP_W-1:0];
        end else begin
            mac_a_d = {OP_W{1'b0}};
            mac_b_d = {OP_W{1'b0}};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset_p) begin
            state_q    <= ST_IDLE;
            len_q      <= {CNT_W{1'b0}};
            wr_cnt_q   <= {CNT_W{1'b0}};
            rd_cnt_q   <= {CNT_W{1'b0}};
            drain_q    <= {DW{1'b0}};
            result_q   <= {ACC_W{1'b0}};
            mac_a_q    <= {OP_W{1'b0}};
            mac_b_q    <= {OP_W{1'b0}};
            mac_clr_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
`ifdef MAC_SEQ_SAT_FLAG_EN
            sat_flag_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            drain_q    <= drain_d;
            result_q   <= result_d;
            mac_a_q    <= mac_a_d;
            mac_b_q    <= mac_b_d;
            mac_clr_q  <= mac_clr_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
`ifdef MAC_SEQ_SAT_FLAG_EN
            sat_flag_q <= sat_flag_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign mac_a    = mac_a_q;
    assign mac_b    = mac_b_q;
    assign mac_clr  = mac_clr_q;
    assign result   = result_q;
    assign done     = done_q;
    assign busy     = busy_q;
`ifdef MAC_SEQ_SAT_FLAG_EN
    assign sat_flag = sat_flag_q;
`endif

endmodule
